// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode width, branch condition codes, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int OPCODE_W    = 5;
    localparam int CPU_INSTR_W = 16;

    typedef enum logic [1:0] {
        BR_ALWAYS = 2'd0,
        BR_Z      = 2'd1,
        BR_N      = 2'd2,
        BR_NEVER  = 2'd3
    } br_cond_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EXEC  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port shared between fetch_unit and the memory.
// Latency: read data is valid exactly one cycle after i_rd.
// Backpressure: none; the memory has no wait states.
// Ports: i_addr/i_rd driven by the fetch side (master), i_rddata by memory (slave).
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic [ADDR_W-1:0]  i_addr;
    logic               i_rd;
    logic [INSTR_W-1:0] i_rddata;

    modport master (output i_addr, output i_rd, input  i_rddata);
    modport slave  (input  i_addr, input  i_rd, output i_rddata);
endinterface

// File: rtl/fetch_unit_branch_resolve.sv
// Branch resolution: taken decision and next PC from flags and decoder controls.
// Latency: purely combinational.
// Backpressure: none.
// Ports: pc/flags/controls in; pc_plus2, taken, next_pc out.
module branch_resolve
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              n_flag,
    input  logic              z_flag,
    input  logic              pc_src,
    input  logic              br_src,
    input  br_cond_t          br_cond,
    input  logic [ADDR_W-1:0] rd1,
    input  logic [ADDR_W-1:0] imm_ext,
    output logic [ADDR_W-1:0] pc_plus2,
    output logic              taken,
    output logic [ADDR_W-1:0] next_pc
);
    logic              cond_ok;
    logic [ADDR_W-1:0] target;

    always_comb begin
        pc_plus2 = pc + ADDR_W'(2);

        cond_ok = 1'b0;
        case (br_cond)
            BR_ALWAYS: cond_ok = 1'b1;
            BR_Z:      cond_ok = z_flag;
            BR_N:      cond_ok = n_flag;
            default:   cond_ok = 1'b0;
        endcase

        // pc_src=1 means sequential, so only pc_src=0 can branch.
        taken = !pc_src && cond_ok;

        // Additions wrap naturally; bit 0 cleared so the PC stays halfword aligned.
        target    = br_src ? (pc_plus2 + imm_ext) : rd1;
        target[0] = 1'b0;

        next_pc = taken ? target : pc_plus2;
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC-sequencing stage: owns PC, IR and N/Z flags; one instruction per FETCH-WAIT-EXEC.
// Latency: 3 cycles per unstalled instruction; first FETCH one cycle after reset release.
// Backpressure: stall holds EXEC (IR/PC stable, no commit) until released.
// Ports: clk/reset; mem (instruction read port); stall; ir/opcode/ir_valid/pc/pc_plus2 to
//        decode; PCSrc/BrSrc/BrCond/rd1/imm_ext branch controls; NZ/alu_result flag update;
//        n_flag/z_flag/taken status.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_unit_if.master         mem,
    input  logic                 stall,
    output logic [INSTR_W-1:0]   ir,
    output logic [OPCODE_W-1:0]  opcode,
    output logic                 ir_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    pc_plus2,
    input  logic                 PCSrc,
    input  logic                 BrSrc,
    input  logic [1:0]           BrCond,
    input  logic [ADDR_W-1:0]    rd1,
    input  logic [ADDR_W-1:0]    imm_ext,
    input  logic                 NZ,
    input  logic [15:0]          alu_result,
    output logic                 n_flag,
    output logic                 z_flag,
    output logic                 taken
);
    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               n_q, n_d;
    logic               z_q, z_d;

    logic               br_taken;
    logic [ADDR_W-1:0]  next_pc;

    // Flags fed in are the pre-commit values, so an instruction's own NZ
    // update never influences its own branch.
    branch_resolve #(.ADDR_W(ADDR_W)) u_branch_resolve (
        .pc       (pc_q),
        .n_flag   (n_q),
        .z_flag   (z_q),
        .pc_src   (PCSrc),
        .br_src   (BrSrc),
        .br_cond  (br_cond_t'(BrCond)),
        .rd1      (rd1),
        .imm_ext  (imm_ext),
        .pc_plus2 (pc_plus2),
        .taken    (br_taken),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        n_d     = n_q;
        z_d     = z_q;

        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                // Only place read data is captured: one cycle after i_rd.
                ir_d    = mem.i_rddata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (!stall) begin
                    pc_d = next_pc;
                    if (NZ) begin
                        z_d = (alu_result == 16'd0);
                        n_d = alu_result[15];
                    end
                    state_d = ST_FETCH;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign mem.i_rd   = (state_q == ST_FETCH);
    assign mem.i_addr = pc_q;
    assign ir         = ir_q;
    assign opcode     = ir_q[OPCODE_W-1:0];
    assign ir_valid   = (state_q == ST_EXEC);
    assign pc         = pc_q;
    assign n_flag     = n_q;
    assign z_flag     = z_q;
    // Branch controls are only meaningful while an instruction is executing.
    assign taken      = ir_valid && br_taken;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [15:0] ir;
    logic [4:0]  opcode;
    logic        ir_valid;
    logic [15:0] pc, pc_plus2;
    logic        PCSrc = 1'b0, BrSrc = 1'b0;
    logic [1:0]  BrCond = 2'd0;
    logic [15:0] rd1 = '0, imm_ext = '0;
    logic        NZ = 1'b0;
    logic [15:0] alu_result = '0;
    logic        n_flag, z_flag, taken;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, advanced from the architectural rules per instruction.
    logic [15:0] model_pc = 16'h0000;
    logic        model_n  = 1'b0;
    logic        model_z  = 1'b0;

    typedef struct {
        logic        pcsrc;
        logic        brsrc;
        logic [1:0]  brcond;
        logic [15:0] rd1;
        logic [15:0] imm;
        logic        nz;
        logic [15:0] alu;
        int          stall_cyc;
        logic [15:0] exp_pc;
        logic        exp_taken;
        logic [15:0] exp_next;
        logic        exp_n;
        logic        exp_z;
    } vec_t;

    vec_t tbl[12];

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) mif ();

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (mif),
        .stall      (stall),
        .ir         (ir),
        .opcode     (opcode),
        .ir_valid   (ir_valid),
        .pc         (pc),
        .pc_plus2   (pc_plus2),
        .PCSrc      (PCSrc),
        .BrSrc      (BrSrc),
        .BrCond     (BrCond),
        .rd1        (rd1),
        .imm_ext    (imm_ext),
        .NZ         (NZ),
        .alu_result (alu_result),
        .n_flag     (n_flag),
        .z_flag     (z_flag),
        .taken      (taken)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0001;
        return {a[7:0] ^ 8'hA5, a[15:8] ^ 8'h3C};
    endfunction

    // Memory: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk)
        mif.i_rddata <= mif.i_rd ? mem_word(mif.i_addr) : 16'hDEAD;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_i_rd"},     16'(mif.i_rd),  16'h0);
        chk({tag, "_i_addr"},   mif.i_addr,     16'h0000);
        chk({tag, "_ir"},       ir,             16'h0000);
        chk({tag, "_opcode"},   16'(opcode),    16'h0);
        chk({tag, "_ir_valid"}, 16'(ir_valid),  16'h0);
        chk({tag, "_pc"},       pc,             16'h0000);
        chk({tag, "_pc_plus2"}, pc_plus2,       16'h0002);
        chk({tag, "_n_flag"},   16'(n_flag),    16'h0);
        chk({tag, "_z_flag"},   16'(z_flag),    16'h0);
        chk({tag, "_taken"},    16'(taken),     16'h0);
    endtask

    function automatic vec_t mk(input logic pcsrc, input logic brsrc, input logic [1:0] brcond,
                                input logic [15:0] r, input logic [15:0] imm, input logic nz,
                                input logic [15:0] alu, input int st, input logic [15:0] epc,
                                input logic etk, input logic [15:0] enx, input logic en,
                                input logic ez);
        vec_t v;
        v.pcsrc = pcsrc; v.brsrc = brsrc; v.brcond = brcond; v.rd1 = r; v.imm = imm;
        v.nz = nz; v.alu = alu; v.stall_cyc = st; v.exp_pc = epc; v.exp_taken = etk;
        v.exp_next = enx; v.exp_n = en; v.exp_z = ez;
        return v;
    endfunction

    // Executes one full instruction and checks every phase of it.
    task automatic run_instr(input vec_t v, input string tag);
        int valid_cnt = 0;
        for (int n = 0; n < 6 && mif.i_rd !== 1'b1; n++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_fetch_rd"},   16'(mif.i_rd), 16'h1);
        chk({tag, "_fetch_addr"}, mif.i_addr,    v.exp_pc);
        chk({tag, "_fetch_tk"},   16'(taken),    16'h0);

        @(negedge clk); #1;
        chk({tag, "_wait_rd"},    16'(mif.i_rd),   16'h0);
        chk({tag, "_wait_vld"},   16'(ir_valid),   16'h0);

        @(negedge clk);
        PCSrc = v.pcsrc; BrSrc = v.brsrc; BrCond = v.brcond; rd1 = v.rd1;
        imm_ext = v.imm; NZ = v.nz; alu_result = v.alu; stall = (v.stall_cyc != 0);
        #1;
        if (ir_valid === 1'b1) valid_cnt++;
        chk({tag, "_ir"},       ir,            mem_word(v.exp_pc));
        chk({tag, "_opcode"},   16'(opcode),   16'(mem_word(v.exp_pc) & 16'h001F));
        chk({tag, "_ir_valid"}, 16'(ir_valid), 16'h1);
        chk({tag, "_pc"},       pc,            v.exp_pc);
        chk({tag, "_pc_plus2"}, pc_plus2,      v.exp_pc + 16'd2);
        chk({tag, "_taken"},    16'(taken),    16'(v.exp_taken));
        chk({tag, "_n_old"},    16'(n_flag),   16'(model_n));
        chk({tag, "_z_old"},    16'(z_flag),   16'(model_z));

        for (int k = 1; k <= v.stall_cyc; k++) begin
            @(negedge clk);
            stall = (k < v.stall_cyc);
            #1;
            if (ir_valid === 1'b1) valid_cnt++;
            chk({tag, "_stl_pc"},    pc,            v.exp_pc);
            chk({tag, "_stl_ir"},    ir,            mem_word(v.exp_pc));
            chk({tag, "_stl_n"},     16'(n_flag),   16'(model_n));
            chk({tag, "_stl_z"},     16'(z_flag),   16'(model_z));
            chk({tag, "_stl_rd"},    16'(mif.i_rd), 16'h0);
            chk({tag, "_stl_taken"}, 16'(taken),    16'(v.exp_taken));
        end
        chk({tag, "_vld_cycles"}, 16'(valid_cnt), 16'(v.stall_cyc + 1));

        @(negedge clk);
        stall = 1'b0;
        #1;
        chk({tag, "_next_pc"},  pc,            v.exp_next);
        chk({tag, "_n_new"},    16'(n_flag),   16'(v.exp_n));
        chk({tag, "_z_new"},    16'(z_flag),   16'(v.exp_z));
        chk({tag, "_post_vld"}, 16'(ir_valid), 16'h0);
        chk({tag, "_post_rd"},  16'(mif.i_rd), 16'h1);
        chk({tag, "_post_adr"}, mif.i_addr,    v.exp_next);

        model_pc = v.exp_next;
        model_n  = v.exp_n;
        model_z  = v.exp_z;
    endtask

    // Builds a random instruction and derives its expected outcome from the rules.
    function automatic vec_t rand_vec();
        vec_t v;
        logic [15:0] tgt;
        logic        cond;
        v.pcsrc     = 1'($urandom_range(0, 1));
        v.brsrc     = 1'($urandom_range(0, 1));
        v.brcond    = 2'($urandom_range(0, 3));
        v.rd1       = 16'($urandom);
        v.imm       = 16'($urandom);
        v.nz        = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
            0:       v.alu = 16'h0000;
            1:       v.alu = 16'h8000 | 16'($urandom);
            default: v.alu = 16'($urandom);
        endcase
        v.stall_cyc = int'($urandom_range(0, 3));
        v.exp_pc    = model_pc;
        cond = (v.brcond == 2'd0) || (v.brcond == 2'd1 && model_z) || (v.brcond == 2'd2 && model_n);
        v.exp_taken = !v.pcsrc && cond;
        tgt = v.brsrc ? 16'((32'(model_pc) + 2 + 32'(v.imm)) % 65536) : v.rd1;
        tgt = 16'((int'(tgt) / 2) * 2);
        v.exp_next  = v.exp_taken ? tgt : 16'((32'(model_pc) + 2) % 65536);
        v.exp_n     = v.nz ? v.alu[15] : model_n;
        v.exp_z     = v.nz ? (v.alu == 16'h0000) : model_z;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        //           pcsrc brsrc cond rd1       imm       nz  alu       stl pc        tk  next      n  z
        tbl[0]  = mk(1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 2'd0, 16'h000E, 16'h0000, 1'b0, 16'h0000, 0, 16'h0002, 1'b1, 16'h000E, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 0, 16'h000E, 1'b0, 16'h0010, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b1, 2'd1, 16'h0000, 16'hFFFC, 1'b0, 16'h0000, 4, 16'h0010, 1'b1, 16'h000E, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 2'd2, 16'h1235, 16'h0000, 1'b1, 16'h8001, 0, 16'h000E, 1'b0, 16'h0010, 1'b1, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 2'd2, 16'h1235, 16'h0000, 1'b0, 16'h0000, 0, 16'h0010, 1'b1, 16'h1234, 1'b1, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 2'd1, 16'h0000, 16'h0040, 1'b0, 16'h0000, 0, 16'h1234, 1'b0, 16'h1236, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 2'd3, 16'h0000, 16'h0000, 1'b0, 16'h0000, 0, 16'h1236, 1'b0, 16'h1238, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 2'd0, 16'h4444, 16'h0000, 1'b0, 16'h0000, 0, 16'h1238, 1'b0, 16'h123A, 1'b1, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 2'd0, 16'hFFFF, 16'h0000, 1'b1, 16'h7FFF, 0, 16'h123A, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 2'd0, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);

        // Reset state, with branch controls set to "always taken" to expose ungated taken.
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("rst");

        // Release: one IDLE cycle, then FETCH of RESET_PC.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_rd", 16'(mif.i_rd), 16'h0);
        @(negedge clk); #1;
        chk("first_fetch_rd",   16'(mif.i_rd), 16'h1);
        chk("first_fetch_addr", mif.i_addr,    16'h0000);

        for (int i = 0; i < 12; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 40; i++) run_instr(rand_vec(), $sformatf("rnd%0d", i));

        // Reset in WAIT: immediate return to reset values, in-flight data dropped.
        @(negedge clk); #1;
        chk("mid_wait_rd", 16'(mif.i_rd), 16'h0);
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("midrst_hold");
        reset = 1'b0;
        model_pc = 16'h0000;
        model_n  = 1'b0;
        model_z  = 1'b0;
        @(negedge clk); #1;
        chk("restart_fetch_rd", 16'(mif.i_rd), 16'h1);
        run_instr(tbl[0], "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
